// File: rtl/fetch_exec_ctrl_if.sv
// Word-wide memory port shared by instruction fetch and data load/store.
// The controller drives the request side; the memory answers with rdata/ack.
interface fetch_exec_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_addr, mem_we, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/fetch_exec_ctrl.sv
// Multicycle fetch/execute sequencer for the Thumb-subset datapath: owns the PC,
// arbitrates the single memory port between fetch and data access, handles halt/fault.
module fetch_exec_ctrl #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  fetch_exec_ctrl_if.master      mem,
  output logic [15:0]            instr,
  output logic                   exec_en,
  input  logic                   exec_mem,
  input  logic                   exec_we,
  input  logic [31:0]            exec_addr,
  input  logic [31:0]            exec_wdata,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   halt_req,
  output logic [31:0]            load_data,
  output logic                   load_valid,
  output logic [31:0]            pc,
  output logic                   halted,
  output logic                   fault,
  output logic [31:0]            retired
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

  state_t            state_reg;
  logic [31:0]       pc_reg;
  logic [31:0]       retired_reg;
  logic [15:0]       instr_reg;
  logic [31:0]       load_data_reg;
  logic              load_valid_reg;
  logic              exec_en_reg;
  logic              halted_reg;
  logic              fault_reg;
  logic              mem_req_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_we_reg;
  logic [31:0]       mem_wdata_reg;
  logic              br_taken_reg;
  logic [31:0]       br_target_reg;

  logic [31:0]       seq_pc;
  logic [31:0]       exec_next_pc;
  logic [31:0]       mem_next_pc;
  logic              misaligned;
  logic              unused_bits;

  assign seq_pc       = pc_reg + 32'd2;
  assign exec_next_pc = branch_taken ? {branch_target[31:1], 1'b0} : seq_pc;
  // A load/store uses the branch decision captured when it left EXEC.
  assign mem_next_pc  = br_taken_reg ? {br_target_reg[31:1], 1'b0} : seq_pc;
  assign misaligned   = exec_addr[1:0] != 2'b00;
  assign unused_bits  = ^{exec_addr[31:ADDR_W+2], branch_target[0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      retired_reg    <= 32'd0;
      instr_reg      <= 16'd0;
      load_data_reg  <= 32'd0;
      load_valid_reg <= 1'b0;
      exec_en_reg    <= 1'b0;
      halted_reg     <= 1'b0;
      fault_reg      <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      mem_we_reg     <= 1'b0;
      mem_wdata_reg  <= 32'd0;
      br_taken_reg   <= 1'b0;
      br_target_reg  <= 32'd0;
    end else begin
      exec_en_reg    <= 1'b0;
      load_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (run) begin
            state_reg    <= FETCH;
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= pc_reg[ADDR_W+1:2];
            mem_we_reg   <= 1'b0;
          end
        end
        FETCH: begin
          if (mem.mem_ack) begin
            instr_reg   <= pc_reg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
            mem_req_reg <= 1'b0;
            exec_en_reg <= 1'b1;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          if (halt_req) begin
            state_reg   <= HALT;
            halted_reg  <= 1'b1;
            retired_reg <= retired_reg + 32'd1;
          end else if (exec_mem && misaligned) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
            fault_reg  <= 1'b1;
          end else if (exec_mem) begin
            mem_addr_reg  <= exec_addr[ADDR_W+1:2];
            mem_we_reg    <= exec_we;
            mem_wdata_reg <= exec_wdata;
            mem_req_reg   <= 1'b1;
            br_taken_reg  <= branch_taken;
            br_target_reg <= branch_target;
            state_reg     <= MEM;
          end else begin
            pc_reg      <= exec_next_pc;
            retired_reg <= retired_reg + 32'd1;
            if (run) begin
              state_reg    <= FETCH;
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= exec_next_pc[ADDR_W+1:2];
              mem_we_reg   <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        MEM: begin
          if (mem.mem_ack) begin
            if (!mem_we_reg) begin
              load_data_reg  <= mem.mem_rdata;
              load_valid_reg <= 1'b1;
            end
            pc_reg      <= mem_next_pc;
            retired_reg <= retired_reg + 32'd1;
            mem_we_reg  <= 1'b0;
            if (run) begin
              state_reg    <= FETCH;
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= mem_next_pc[ADDR_W+1:2];
            end else begin
              state_reg   <= IDLE;
              mem_req_reg <= 1'b0;
            end
          end
        end
        HALT: begin
          mem_req_reg <= 1'b0;
        end
        default: begin
          state_reg   <= HALT;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_wdata = mem_wdata_reg;

  assign instr      = instr_reg;
  assign exec_en    = exec_en_reg;
  assign load_data  = load_data_reg;
  assign load_valid = load_valid_reg;
  assign pc         = pc_reg;
  assign halted     = halted_reg;
  assign fault      = fault_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Directed bench: stimulus pushes expected fetch/load/exec events into queues,
// a negedge monitor pops and compares whenever the controller presents one.
module tb_fetch_exec_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic        exec_en;
  logic        exec_mem;
  logic        exec_we;
  logic [31:0] exec_addr;
  logic [31:0] exec_wdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt_req;
  logic [31:0] load_data;
  logic        load_valid;
  logic [31:0] pc;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  fetch_exec_ctrl_if #(.ADDR_W(10)) bus ();

  fetch_exec_ctrl #(.ADDR_W(10), .RESET_PC(32'h0000_0000)) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .mem           (bus),
    .instr         (instr),
    .exec_en       (exec_en),
    .exec_mem      (exec_mem),
    .exec_we       (exec_we),
    .exec_addr     (exec_addr),
    .exec_wdata    (exec_wdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .pc            (pc),
    .halted        (halted),
    .fault         (fault),
    .retired       (retired)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_exec_cyc = 0;

  // Memory model: ack arrives after ack_delay cycles of an outstanding request.
  logic [31:0] mem_model [0:1023];
  int          wait_cnt  = 0;
  int          ack_delay = 0;

  assign bus.mem_rdata = mem_model[bus.mem_addr];
  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
    if (bus.mem_req && bus.mem_ack && bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
  end

  logic [9:0]  exp_maddr [$];
  logic        exp_mwe   [$];
  logic [31:0] exp_load  [$];
  logic [15:0] exp_instr [$];
  logic [31:0] exp_pc    [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_mem(input logic [9:0] a, input logic w);
    exp_maddr.push_back(a);
    exp_mwe.push_back(w);
  endtask

  // Monitor: one line per observed transaction.
  logic [9:0]  m_addr;
  logic        m_we;
  logic [31:0] m_load;
  logic [15:0] m_instr;
  logic [31:0] m_pc;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.mem_req && bus.mem_ack) begin
        if (exp_maddr.size() == 0) begin
          chk("mem_unexpected", {22'd0, bus.mem_addr}, 32'hFFFF_FFFF);
        end else begin
          m_addr = exp_maddr.pop_front();
          m_we   = exp_mwe.pop_front();
          chk("mem_addr", {22'd0, bus.mem_addr}, {22'd0, m_addr});
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, m_we});
          $display("mem  addr=%0d we=%0b rdata=%h", bus.mem_addr, bus.mem_we, bus.mem_rdata);
        end
      end
      if (load_valid) begin
        if (exp_load.size() == 0) begin
          chk("load_unexpected", load_data, 32'hFFFF_FFFF);
        end else begin
          m_load = exp_load.pop_front();
          chk("load_data", load_data, m_load);
          $display("load data=%h", load_data);
        end
      end
      if (exec_en) begin
        if (exp_instr.size() == 0) begin
          chk("exec_unexpected", {16'd0, instr}, 32'hFFFF_FFFF);
        end else begin
          m_instr = exp_instr.pop_front();
          m_pc    = exp_pc.pop_front();
          chk("exec_instr", {16'd0, instr}, {16'd0, m_instr});
          chk("exec_pc", pc, m_pc);
          $display("exec instr=%h pc=%h retired=%0d", instr, pc, retired);
        end
      end
    end
  end

  // Waits for the next execute cycle, drives the datapath response for it,
  // and returns #1 after the edge that samples that response.
  task automatic exec_step(input logic [15:0] e_instr, input logic [31:0] e_pc,
                           input logic m, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic br, input logic [31:0] tgt,
                           input logic hlt, input logic run_after, input bit chk_gap);
    bit found = 0;
    exp_instr.push_back(e_instr);
    exp_pc.push_back(e_pc);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (exec_en) found = 1;
    end
    chk("exec_seen", {31'd0, found}, 32'd1);
    if (found) begin
      if (chk_gap) chk("exec_gap", cyc - last_exec_cyc, 32'd2);
      last_exec_cyc = cyc;
      exec_mem      = m;
      exec_we       = w;
      exec_addr     = a;
      exec_wdata    = wd;
      branch_taken  = br;
      branch_target = tgt;
      halt_req      = hlt;
      run           = run_after;
      @(posedge clock);
      #1;
    end
    exec_mem = 0; exec_we = 0; exec_addr = 0; exec_wdata = 0;
    branch_taken = 0; branch_target = 0; halt_req = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_retired"}, retired, 32'h0);
    chk({tag, "_instr"}, {16'd0, instr}, 32'h0);
    chk({tag, "_load_data"}, load_data, 32'h0);
    chk({tag, "_flags"}, {26'd0, bus.mem_req, bus.mem_we, exec_en, load_valid, halted, fault}, 32'h0);
    chk({tag, "_mem_addr"}, {22'd0, bus.mem_addr}, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    run   = 0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state(tag);
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
    mem_model[0]  = 32'h2001_2002;
    mem_model[1]  = 32'h2004_2003;
    mem_model[2]  = 32'h3006_3005;
    mem_model[4]  = 32'hDEAD_BEEF;
    mem_model[16] = 32'h4008_4007;
    exec_mem = 0; exec_we = 0; exec_addr = 0; exec_wdata = 0;
    branch_taken = 0; branch_target = 0; halt_req = 0;
    run = 0;

    do_reset("rst0");

    // Straight-line run, delayed fetch, load, branch, halt.
    push_mem(10'd0, 1'b0);
    push_mem(10'd0, 1'b0);
    push_mem(10'd1, 1'b0);
    push_mem(10'd1, 1'b0);
    push_mem(10'd4, 1'b0);
    push_mem(10'd2, 1'b0);
    push_mem(10'd16, 1'b0);
    exp_load.push_back(32'hDEAD_BEEF);
    run = 1;
    exec_step(16'h2002, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    exec_step(16'h2001, 32'h2, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("seq_retired", retired, 32'd2);
    chk("seq_pc", pc, 32'h4);

    ack_delay = 3;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'd0, bus.mem_req}, 32'd1);
      chk("wait_addr", {22'd0, bus.mem_addr}, 32'd1);
      chk("wait_no_exec", {31'd0, exec_en}, 32'd0);
      @(posedge clock);
      #1;
    end
    ack_delay = 0;
    exec_step(16'h2003, 32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    exec_step(16'h2004, 32'h6, 1, 0, 32'h10, 32'h5555_AAAA, 0, 0, 0, 1, 0);
    exec_step(16'h3005, 32'h8, 0, 0, 0, 0, 1, 32'h41, 0, 1, 0);
    chk("branch_pc", pc, 32'h40);
    exec_step(16'h4007, 32'h40, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("halt_flags", {30'd0, halted, fault}, 32'h2);
    chk("halt_retired", retired, 32'd6);
    chk("halt_pc", pc, 32'h40);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      chk("halt_no_req", {31'd0, bus.mem_req}, 32'd0);
    end

    do_reset("rst1");

    // run dropped during a load, then a misaligned store faults.
    push_mem(10'd0, 1'b0);
    push_mem(10'd4, 1'b0);
    push_mem(10'd0, 1'b0);
    exp_load.push_back(32'hDEAD_BEEF);
    run = 1;
    exec_step(16'h2002, 32'h0, 1, 0, 32'h10, 0, 0, 0, 0, 1, 0);
    run = 0;
    repeat (4) @(posedge clock);
    #1;
    chk("park_req", {31'd0, bus.mem_req}, 32'd0);
    chk("park_pc", pc, 32'h2);
    chk("park_retired", retired, 32'd1);
    run = 1;
    exec_step(16'h2001, 32'h2, 1, 1, 32'h12, 32'h1234_5678, 0, 0, 0, 1, 0);
    chk("fault_flags", {30'd0, halted, fault}, 32'h3);
    chk("fault_retired", retired, 32'd1);
    chk("fault_pc", pc, 32'h2);
    for (int i = 0; i < 4; i++) begin
      chk("fault_no_req", {31'd0, bus.mem_req}, 32'd0);
      @(posedge clock);
      #1;
    end

    do_reset("rst2");
    repeat (2) @(posedge clock);

    chk("left_mem", exp_maddr.size(), 32'd0);
    chk("left_load", exp_load.size(), 32'd0);
    chk("left_exec", exp_instr.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_exec_ctrl.md
Name: fetch_exec_ctrl

Overview:
- Multicycle sequencer for the Thumb-subset emulator datapath.
- Owns the PC and the single 32-bit word memory port. Fetches 16-bit halfwords and presents them to the decode/execute datapath.
- Arbitrates the memory port between instruction fetch and the data load/store requested by the executing instruction.
- Handles branch redirect, SVC halt and misaligned-access fault.

Parameters:
- ADDR_W, 10, word-address width of the memory port (1024 words).
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  a new fetch starts only while high; an instruction already in flight always completes.
- mem_req  out  1  memory request, held until acknowledged.
- mem_addr  out  ADDR_W  word address.
- mem_we  out  1  write enable (data stores only).
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the mem_ack cycle.
- mem_ack  in  1  request complete; sampled only while mem_req=1.
- instr  out  16  latched current instruction.
- exec_en  out  1  one-cycle execute strobe to the datapath.
- exec_mem  in  1  instruction needs a data access (valid while exec_en=1).
- exec_we  in  1  data access is a store.
- exec_addr  in  32  data byte address.
- exec_wdata  in  32  store data.
- branch_taken  in  1  redirect the PC (valid while exec_en=1).
- branch_target  in  32  new PC byte address.
- halt_req  in  1  SVC 100 executed (valid while exec_en=1).
- load_data  out  32  loaded word.
- load_valid  out  1  one-cycle pulse; load_data is valid.
- pc  out  32  byte address of the current/next instruction.
- halted  out  1  sticky; set by halt or fault.
- fault  out  1  sticky; set by a misaligned data access.
- retired  out  32  count of completed instructions.

Behaviour:
- Async reset:
  - state=IDLE; pc=RESET_PC; retired=0.
  - instr, load_data, mem_addr, mem_wdata = 0.
  - mem_req, mem_we, exec_en, load_valid, halted, fault = 0.
  - mem_req drops immediately, including mid-transaction.
- States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE:
  - If run=1, go to FETCH next cycle.
  - Register mem_req=1 and mem_addr=pc[ADDR_W+1:2], mem_we=0, on entry.
- FETCH:
  - Hold mem_req, mem_addr and mem_we stable until mem_ack.
  - On ack, latch instr: mem_rdata[15:0] if pc[1]=0, else mem_rdata[31:16] (little-endian).
  - On ack, drop mem_req and go to EXEC.
  - pc bits beyond ADDR_W+1 are ignored, so addressing wraps.
- EXEC:
  - exec_en=1 for exactly this cycle; controller samples the datapath inputs at the end of the cycle.
  - Priority 1, halt_req=1: go to HALT, set halted, retired+1, pc unchanged.
  - Priority 2, exec_mem=1 and exec_addr[1:0]!=0: go to HALT, set fault and halted, no memory request, retired unchanged.
  - Priority 3, exec_mem=1 (aligned): latch exec_addr[ADDR_W+1:2], exec_we and exec_wdata into the mem_* registers, raise mem_req, go to MEM. Latch branch_taken and branch_target.
  - Otherwise: update the PC, retired+1, then go to FETCH if run=1, else IDLE.
- MEM:
  - Hold mem_req until mem_ack.
  - On ack of a load: load_data=mem_rdata and load_valid=1 in the following cycle.
  - On ack of a store: no load_valid.
  - Then update the PC, retired+1, and go to FETCH or IDLE per run.
- PC update:
  - Branch: pc = {branch_target[31:1],1'b0}, since bit 0 is always cleared.
  - No branch: pc = pc+2, 32-bit wrap.
- HALT:
  - mem_req=0 and exec_en=0.
  - Ignores run and mem_ack; exits only via reset.
- Stray mem_ack while mem_req=0 is ignored.
- Latency with zero-wait memory: 2 cycles for a non-memory instruction (FETCH+EXEC), 3 for load/store.
- run deasserted: the current instruction finishes; the controller parks in IDLE with pc pointing at the next instruction.
- retired wraps from 32'hFFFF_FFFF to 0.

Test Plan:
- Reset, then run=1 with mem word0=32'h2001_2002, always-ack memory, no branches. Required: exec_en pulses every 2 cycles; instr=16'h2002 then 16'h2001; pc steps 0→2→4; retired=2 after the second exec.
- Fetch with mem_ack delayed 3 cycles. Required: mem_req and mem_addr stay stable for those 3 cycles; exactly one exec_en follows; no duplicate fetch.
- Load with exec_mem=1, exec_we=0, exec_addr=32'h10, word 4=32'hDEAD_BEEF. Required: mem_addr=4, mem_we=0; load_valid pulses once with load_data=32'hDEAD_BEEF; pc+2.
- Store with exec_addr=32'h12 (misaligned). Required: no mem_req; fault=1, halted=1; retired unchanged. Then reset. Required: all outputs return to reset values.
- Branch with branch_target=32'h41. Required: pc=32'h40; the next fetch has mem_addr=16 and takes the low halfword. Then halt_req=1. Required: halted=1; no further mem_req even with run=1.
- run dropped during MEM. Required: the load completes; IDLE is entered with pc advanced; fetching resumes when run rises.
